// File: rtl/dac_segment_encoder_if.sv
// Code handshake from the upstream source plus the registered driver bus
// (power-down-bar, binary and thermometer fields with complements) to driver_cell.
interface dac_segment_encoder_if #(
   parameter int BIN_W   = 7,
   parameter int THERM_W = 17,
   parameter int IN_W    = 12
);
   logic               en;
   logic [IN_W-1:0]    code_in;
   logic               code_valid;
   logic               code_ready;
   logic               pdb;
   logic [BIN_W-1:0]   datain;
   logic [BIN_W-1:0]   datainb;
   logic [THERM_W-1:0] datatherm;
   logic [THERM_W-1:0] datathermb;
   logic               sat_flag;

   modport master (
      output en, code_in, code_valid,
      input  code_ready, pdb, datain, datainb, datatherm, datathermb, sat_flag
   );

   modport slave (
      input  en, code_in, code_valid,
      output code_ready, pdb, datain, datainb, datatherm, datathermb, sat_flag
   );
endinterface

// File: rtl/dac_segment_encoder.sv
// Segmented DAC front-end: saturates a code, splits it into binary LSBs and thermometer
// MSBs over a 2-stage registered pipeline, and sequences pdb around the zero code.
module dac_segment_encoder #(
   parameter int BIN_W         = 7,
   parameter int THERM_W       = 17,
   parameter int IN_W          = 12,
   parameter int SETTLE_CYCLES = 8
) (
   input logic                  clk,
   input logic                  rst,
   dac_segment_encoder_if.slave bus
);
   localparam int              N_W         = IN_W - BIN_W;
   localparam logic [IN_W-1:0] FS_CODE     = IN_W'(THERM_W * (2 ** BIN_W) + (2 ** BIN_W) - 1);
   localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      OFF    = 3'd0,
      WAKE   = 3'd1,
      ACTIVE = 3'd2,
      DRAIN  = 3'd3,
      ZERO   = 3'd4
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [7:0]         cnt_r;
   logic [7:0]         cnt_next_s;
   logic               pdb_r;
   logic               pdb_next_s;
   logic               ready_r;
   logic               ready_next_s;
   logic               load_zero_s;
   logic               xfer_s;

   logic               s1_valid_r;
   logic               s1_sat_r;
   logic [IN_W-1:0]    s1_code_r;

   logic [N_W-1:0]     n_s;
   logic [BIN_W-1:0]   bin_s;
   logic [THERM_W-1:0] therm_s;

   logic [BIN_W-1:0]   datain_r;
   logic [BIN_W-1:0]   datainb_r;
   logic [THERM_W-1:0] datatherm_r;
   logic [THERM_W-1:0] datathermb_r;
   logic               sat_r;

   assign xfer_s = bus.code_valid && ready_r;

   // State register, shared settle/drain counter and registered control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= OFF;
         cnt_r   <= 8'd0;
         pdb_r   <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_next_s;
         pdb_r   <= pdb_next_s;
         ready_r <= ready_next_s;
      end
   end

   // Next-state logic; en=0 aborts WAKE, while DRAIN/ZERO always run to completion
   always_comb begin
      next_state_s = state_r;
      cnt_next_s   = 8'd0;
      case (state_r)
         OFF: begin
            if (bus.en) next_state_s = WAKE;
            else        next_state_s = OFF;
         end
         WAKE: begin
            if (!bus.en)                   next_state_s = OFF;
            else if (cnt_r == SETTLE_LAST) next_state_s = ACTIVE;
            else                           cnt_next_s   = cnt_r + 8'd1;
         end
         ACTIVE: begin
            if (!bus.en) next_state_s = DRAIN;
            else         next_state_s = ACTIVE;
         end
         DRAIN: begin
            if (cnt_r == 8'd1) next_state_s = ZERO;
            else               cnt_next_s   = cnt_r + 8'd1;
         end
         ZERO:    next_state_s = OFF;
         default: next_state_s = OFF;
      endcase
   end

   // Control outputs decoded from the upcoming state so they register with it
   always_comb begin
      pdb_next_s   = 1'b0;
      ready_next_s = 1'b0;
      load_zero_s  = 1'b0;
      case (next_state_s)
         OFF:     pdb_next_s = 1'b0;
         WAKE:    pdb_next_s = 1'b1;
         ACTIVE: begin
            pdb_next_s   = 1'b1;
            ready_next_s = 1'b1;
         end
         DRAIN:   pdb_next_s = 1'b1;
         ZERO: begin
            pdb_next_s  = 1'b1;
            load_zero_s = (state_r != ZERO);
         end
         default: pdb_next_s = 1'b0;
      endcase
   end

   // Stage 1: capture the saturated code on a transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_sat_r   <= 1'b0;
         s1_code_r  <= '0;
      end else begin
         s1_valid_r <= xfer_s;
         if (xfer_s) begin
            s1_sat_r  <= (bus.code_in > FS_CODE);
            s1_code_r <= (bus.code_in > FS_CODE) ? FS_CODE : bus.code_in;
         end else begin
            s1_sat_r  <= s1_sat_r;
            s1_code_r <= s1_code_r;
         end
      end
   end

   // Segment decode: the upper bits count how many thermometer lines are on
   always_comb begin
      therm_s = '0;
      n_s     = s1_code_r[IN_W-1:BIN_W];
      bin_s   = s1_code_r[BIN_W-1:0];
      for (int i = 0; i < THERM_W; i++) begin
         therm_s[i] = (N_W'(i) < n_s);
      end
   end

   // Stage 2: output registers; true and complement rails load together
   always_ff @(posedge clk) begin
      if (rst || load_zero_s) begin
         datain_r     <= '0;
         datainb_r    <= '1;
         datatherm_r  <= '0;
         datathermb_r <= '1;
         sat_r        <= 1'b0;
      end else if (s1_valid_r) begin
         datain_r     <= bin_s;
         datainb_r    <= ~bin_s;
         datatherm_r  <= therm_s;
         datathermb_r <= ~therm_s;
         sat_r        <= s1_sat_r;
      end else begin
         datain_r     <= datain_r;
         datainb_r    <= datainb_r;
         datatherm_r  <= datatherm_r;
         datathermb_r <= datathermb_r;
         sat_r        <= 1'b0;
      end
   end

   assign bus.code_ready = ready_r;
   assign bus.pdb        = pdb_r;
   assign bus.datain     = datain_r;
   assign bus.datainb    = datainb_r;
   assign bus.datatherm  = datatherm_r;
   assign bus.datathermb = datathermb_r;
   assign bus.sat_flag   = sat_r;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Self-checking bench for dac_segment_encoder: directed power sequencing plus randomized
// code streams compared against an arithmetic reference of the segment split.
module tb_dac_segment_encoder;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   errors   = 0;
   int   cur_code = 0;

   dac_segment_encoder_if #(.BIN_W(7), .THERM_W(17), .IN_W(12)) bus ();

   dac_segment_encoder #(.BIN_W(7), .THERM_W(17), .IN_W(12), .SETTLE_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [50:0] obs;
   assign obs = {bus.pdb, bus.code_ready, bus.sat_flag, bus.datain, bus.datainb,
                 bus.datatherm, bus.datathermb};

   // Reference: {pdb, ready, sat, bin, ~bin, therm, ~therm} for a code
   function automatic logic [50:0] expv(input bit p, input bit r, input bit s, input int code);
      int         c;
      logic [17:0] t;
      logic [6:0]  b;
      c = (code > 2303) ? 2303 : code;
      t = (18'd1 << (c / 128)) - 18'd1;
      b = 7'(c % 128);
      return {p, r, s, b, ~b, t[16:0], ~t[16:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complement rails must mirror the true rails on every cycle
   always @(negedge clk) begin
      checks++;
      if (bus.datainb !== ~bus.datain || bus.datathermb !== ~bus.datatherm) begin
         errors++;
         $display("FAIL complement: datain=%h datainb=%h therm=%h thermb=%h",
                  bus.datain, bus.datainb, bus.datatherm, bus.datathermb);
      end
   end

   task automatic test_reset();
      logic [50:0] e;
      rst = 1'b1; bus.en = 1'b0; bus.code_valid = 1'b0; bus.code_in = 12'd0;
      tick();
      tick();
      e = expv(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset: got %h expected %h", obs, e); end
      rst = 1'b0;
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL off_idle: got %h expected %h", obs, e); end
      cur_code = 0;
   endtask

   task automatic test_power_up();
      logic [50:0] e;
      bus.en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         e = expv(1'b1, 1'b0, 1'b0, 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL wake_early k=%0d: got %h expected %h", k, obs, e); end
      end
      bus.en = 1'b0;
      tick();
      e = expv(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL wake_abort: got %h expected %h", obs, e); end
      bus.en = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         e = expv(1'b1, (k == 9), 1'b0, 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL power_up k=%0d: got %h expected %h", k, obs, e); end
      end
   endtask

   task automatic test_single();
      logic [50:0] e;
      bus.code_in = 12'd1237; bus.code_valid = 1'b1;
      tick();
      bus.code_valid = 1'b0;
      e = expv(1'b1, 1'b1, 1'b0, cur_code);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL single_latency: got %h expected %h", obs, e); end
      tick();
      cur_code = 1237;
      e = expv(1'b1, 1'b1, 1'b0, 1237);
      checks++;
      if (obs !== e || bus.datatherm !== 17'h001FF || bus.datain !== 7'h55) begin
         errors++; $display("FAIL single_1237: got %h expected %h", obs, e);
      end
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL single_hold: got %h expected %h", obs, e); end
   endtask

   task automatic test_back_to_back();
      int          fixed [4];
      bit          pend_v;
      int          pend;
      bit          v;
      int          c;
      bit          s;
      logic [50:0] e;
      fixed = '{0, 2303, 4095, 128};
      pend_v = 1'b0;
      pend   = 0;
      for (int i = 0; i < 40; i++) begin
         if (i < 4) begin
            v = 1'b1; c = fixed[i];
         end else if (i < 38) begin
            v = ($urandom_range(0, 3) != 0); c = $urandom_range(0, 4095);
         end else begin
            v = 1'b0; c = 0;
         end
         bus.code_valid = v;
         bus.code_in    = c[11:0];
         tick();
         s = 1'b0;
         if (pend_v) begin
            cur_code = pend;
            s = (pend > 2303);
         end
         pend_v = v;
         pend   = c;
         e = expv(1'b1, 1'b1, s, cur_code);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL back_to_back i=%0d: got %h expected %h", i, obs, e); end
      end
      bus.code_valid = 1'b0;
   endtask

   task automatic test_power_down();
      logic [50:0] e;
      bus.en = 1'b0; bus.code_in = 12'd640; bus.code_valid = 1'b1;
      tick();
      bus.code_valid = 1'b0; bus.en = 1'b1;
      e = expv(1'b1, 1'b0, 1'b0, cur_code);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL drain_first: got %h expected %h", obs, e); end
      tick();
      cur_code = 640;
      e = expv(1'b1, 1'b0, 1'b0, 640);
      checks++;
      if (obs !== e || bus.datatherm !== 17'h0001F) begin
         errors++; $display("FAIL drain_640: got %h expected %h", obs, e);
      end
      tick();
      cur_code = 0;
      e = expv(1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL zero_state: got %h expected %h", obs, e); end
      tick();
      e = expv(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL pdb_fall: got %h expected %h", obs, e); end
      tick();
      e = expv(1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rewake: got %h expected %h", obs, e); end
      bus.en = 1'b0;
      tick();
      e = expv(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rewake_off: got %h expected %h", obs, e); end
   endtask

   task automatic test_reset_inflight();
      logic [50:0] e;
      bus.en = 1'b1;
      for (int k = 1; k <= 9; k++) tick();
      e = expv(1'b1, 1'b1, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_active: got %h expected %h", obs, e); end
      bus.code_in = 12'd2000; bus.code_valid = 1'b1;
      tick();
      bus.code_in = 12'd3000; rst = 1'b1;
      tick();
      rst = 1'b0;
      e = expv(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_flush: got %h expected %h", obs, e); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         e = expv(1'b1, 1'b0, 1'b0, 0);
         checks++;
         if (obs !== e) begin errors++; $display("FAIL rst_rewake k=%0d: got %h expected %h", k, obs, e); end
      end
      bus.code_valid = 1'b0; bus.en = 1'b0;
      tick();
      e = expv(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_end: got %h expected %h", obs, e); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_single();
      test_back_to_back();
      test_power_down();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
